// File: rtl/seq_pkg.sv
// Shared state encoding and default geometry for the DRAM access sequencer.
package seq_pkg;

  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_RX_BYTES = 65536;
  localparam int DEF_TX_BYTES = 16384;

  // Codes are visible on the phase port, so the values are fixed.
  typedef enum logic [2:0] {
    ST_LOAD     = 3'd0,
    ST_RUN      = 3'd1,
    ST_TX_READ  = 3'd2,
    ST_TX_LATCH = 3'd3,
    ST_TX_SEND  = 3'd4,
    ST_DONE     = 3'd5
  } seq_state_t;

  function automatic logic is_tx_state(input seq_state_t s);
    return (s == ST_TX_READ) || (s == ST_TX_LATCH) || (s == ST_TX_SEND);
  endfunction

endpackage

// File: rtl/tx_byte_pump.sv
// Read-latch-send byte pump: walks TX_BYTES bytes from TX_BASE out to the transmitter.
module tx_byte_pump
  import seq_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int TX_BASE  = 0,
  parameter int TX_BYTES = DEF_TX_BYTES
) (
  input  logic              clk_in,
  input  logic              clear,
  input  seq_state_t        state,
  input  logic              tx_ready,
  input  logic              cnt_clr,
  input  logic [DATA_W-1:0] dram_q,
  output logic [ADDR_W-1:0] tx_addr,
  output seq_state_t        pump_next,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data
);

  localparam logic [ADDR_W-1:0] TX_BASE_A = ADDR_W'(TX_BASE);
  localparam logic [ADDR_W-1:0] TX_LAST   = ADDR_W'(TX_BYTES - 1);

  logic [ADDR_W-1:0] tx_cnt;

  assign tx_addr = TX_BASE_A + tx_cnt;

  // tx_start is decoded from TX_SEND, which is left on the same edge, so it cannot repeat.
  always_comb begin
    pump_next = state;
    tx_start  = 1'b0;
    case (state)
      ST_TX_READ:  pump_next = ST_TX_LATCH;
      ST_TX_LATCH: pump_next = ST_TX_SEND;
      ST_TX_SEND: begin
        if (tx_ready) begin
          tx_start  = 1'b1;
          pump_next = (tx_cnt == TX_LAST) ? ST_DONE : ST_TX_READ;
        end
      end
      default: pump_next = state;
    endcase
  end

  always_ff @(posedge clk_in or posedge clear) begin
    if (clear) begin
      tx_cnt  <= '0;
      tx_data <= '0;
    end else begin
      if (cnt_clr) begin
        tx_cnt <= '0;
      end else if (tx_start) begin
        tx_cnt <= tx_cnt + ADDR_W'(1);
      end
      // dram_q reflects the TX_READ address during TX_LATCH.
      if (state == ST_TX_LATCH) begin
        tx_data <= dram_q;
      end
    end
  end

endmodule

// File: rtl/dram_access_sequencer.sv
// Frame sequencer: loads received bytes into DRAM, lets the processor run, then streams a result window out.
module dram_access_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RX_BYTES = DEF_RX_BYTES,
  parameter int TX_BASE  = 0,
  parameter int TX_BYTES = DEF_TX_BYTES
) (
  input  logic              clk_in,
  input  logic              clear,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              proc_req,
  input  logic              proc_we,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_wdata,
  input  logic              proc_done,
  output logic              proc_gnt,
  output logic              proc_rvalid,
  output logic [DATA_W-1:0] proc_rdata,
  output logic              enable_processor,
  input  logic              tx_ready,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [DATA_W-1:0] dram_wdata,
  output logic              dram_wren,
  input  logic [DATA_W-1:0] dram_q,
  output logic [2:0]        phase,
  output logic              frame_done,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] RX_LAST = ADDR_W'(RX_BYTES - 1);

  seq_state_t        state_q, state_d, pump_next;
  logic [ADDR_W-1:0] rx_ptr, tx_addr;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] wdata_c;
  logic              wr_c;
  logic              cnt_clr;
  logic              rx_drop;

  tx_byte_pump #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TX_BASE (TX_BASE),
    .TX_BYTES(TX_BYTES)
  ) u_pump (
    .clk_in   (clk_in),
    .clear    (clear),
    .state    (state_q),
    .tx_ready (tx_ready),
    .cnt_clr  (cnt_clr),
    .dram_q   (dram_q),
    .tx_addr  (tx_addr),
    .pump_next(pump_next),
    .tx_start (tx_start),
    .tx_data  (tx_data)
  );

  always_comb begin
    state_d          = state_q;
    addr_c           = '0;
    wdata_c          = '0;
    wr_c             = 1'b0;
    proc_gnt         = 1'b0;
    enable_processor = 1'b0;
    case (state_q)
      ST_LOAD: begin
        addr_c = rx_ptr;
        if (rx_valid) begin
          wr_c    = 1'b1;
          wdata_c = rx_data;
          if (rx_ptr == RX_LAST) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        enable_processor = 1'b1;
        proc_gnt         = proc_req;
        addr_c           = proc_addr;
        wr_c             = proc_req & proc_we;
        wdata_c          = proc_wdata;
        if (proc_done) state_d = ST_TX_READ;
      end
      ST_TX_READ, ST_TX_LATCH, ST_TX_SEND: begin
        addr_c  = tx_addr;
        state_d = pump_next;
      end
      ST_DONE: begin
        // A new frame restarts at address 0; this byte is its first.
        if (rx_valid) begin
          wr_c    = 1'b1;
          wdata_c = rx_data;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Held-off while clear is high so an abandoned frame never reaches the DRAM.
  assign dram_wren  = wr_c & ~clear;
  assign dram_wdata = dram_wren ? wdata_c : '0;
  assign dram_addr  = addr_c;

  assign cnt_clr    = (state_q == ST_DONE) && rx_valid;
  assign rx_drop    = rx_valid && ((state_q == ST_RUN) || is_tx_state(state_q));
  assign proc_rdata = proc_rvalid ? dram_q : '0;
  assign phase      = state_q;
  assign frame_done = (state_q == ST_DONE);

  always_ff @(posedge clk_in or posedge clear) begin
    if (clear) begin
      state_q     <= ST_LOAD;
      rx_ptr      <= '0;
      overrun     <= 1'b0;
      proc_rvalid <= 1'b0;
    end else begin
      state_q     <= state_d;
      proc_rvalid <= (state_q == ST_RUN) && proc_req && !proc_we;
      if (rx_drop) overrun <= 1'b1;
      if ((state_q == ST_LOAD) && rx_valid) begin
        rx_ptr <= (rx_ptr == RX_LAST) ? '0 : rx_ptr + ADDR_W'(1);
      end else if (cnt_clr) begin
        rx_ptr <= ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dram_access_sequencer.sv
// Directed bench for dram_access_sequencer with a small 4-byte frame and a 2-byte transmit window.
module tb_dram_access_sequencer;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  logic              clk_in = 1'b0;
  logic              clear;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              proc_req, proc_we, proc_done;
  logic [ADDR_W-1:0] proc_addr;
  logic [DATA_W-1:0] proc_wdata;
  logic              proc_gnt, proc_rvalid, enable_processor;
  logic [DATA_W-1:0] proc_rdata;
  logic              tx_ready, tx_start;
  logic [DATA_W-1:0] tx_data;
  logic [ADDR_W-1:0] dram_addr;
  logic [DATA_W-1:0] dram_wdata;
  logic              dram_wren;
  logic [DATA_W-1:0] dram_q;
  logic [2:0]        phase;
  logic              frame_done, overrun;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  dram_access_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RX_BYTES(4), .TX_BASE(16'h0010), .TX_BYTES(2)
  ) dut (
    .clk_in(clk_in), .clear(clear), .rx_valid(rx_valid), .rx_data(rx_data),
    .proc_req(proc_req), .proc_we(proc_we), .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .proc_done(proc_done), .proc_gnt(proc_gnt), .proc_rvalid(proc_rvalid),
    .proc_rdata(proc_rdata), .enable_processor(enable_processor), .tx_ready(tx_ready),
    .tx_start(tx_start), .tx_data(tx_data), .dram_addr(dram_addr), .dram_wdata(dram_wdata),
    .dram_wren(dram_wren), .dram_q(dram_q), .phase(phase), .frame_done(frame_done),
    .overrun(overrun)
  );

  always #5 clk_in = ~clk_in;

  // Synchronous DRAM: read-first, data one cycle after the address.
  always @(posedge clk_in) begin
    if (dram_wren) mem[dram_addr] <= dram_wdata;
    dram_q <= mem[dram_addr];
  end

  typedef struct {
    logic        rxv;
    logic [7:0]  rxd;
    logic        req;
    logic        we;
    logic [15:0] paddr;
    logic [7:0]  pwd;
    logic        done;
    logic        rdy;
    logic [2:0]  ph;
    logic        wren;
    logic [15:0] daddr;
    logic [7:0]  dwd;
    logic        gnt;
    logic        rv;
    logic [7:0]  rd;
    logic        en;
    logic        ts;
    logic [7:0]  txd;
    logic        fd;
    logic        ov;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rxv, input logic [7:0] rxd, input logic req, input logic we,
                       input logic [15:0] paddr, input logic [7:0] pwd, input logic done,
                       input logic rdy);
    rx_valid = rxv; rx_data = rxd; proc_req = req; proc_we = we;
    proc_addr = paddr; proc_wdata = pwd; proc_done = done; tx_ready = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rxv rxd   req we paddr    pwd   dn rdy  ph wr daddr    dwd   g rv rd    en ts txd   fd ov
    vecs.push_back('{1, 8'h11, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 1, 16'h0000, 8'h11, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 0, 16'h0001, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0});
    vecs.push_back('{1, 8'h22, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 1, 16'h0001, 8'h22, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0});
    vecs.push_back('{1, 8'h33, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 1, 16'h0002, 8'h33, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0});
    vecs.push_back('{1, 8'h44, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 1, 16'h0003, 8'h44, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 0, 1, 0, 16'h0000, 8'h00, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0});
    vecs.push_back('{0, 8'h00, 1, 0, 16'h0002, 8'h00, 0, 0, 1, 0, 16'h0002, 8'h00, 1, 0, 8'h00, 1, 0, 8'h00, 0, 0});
    vecs.push_back('{0, 8'h00, 1, 1, 16'h0010, 8'hAA, 0, 0, 1, 1, 16'h0010, 8'hAA, 1, 1, 8'h33, 1, 0, 8'h00, 0, 0});
    vecs.push_back('{0, 8'h00, 1, 1, 16'h0011, 8'h3C, 0, 0, 1, 1, 16'h0011, 8'h3C, 1, 0, 8'h00, 1, 0, 8'h00, 0, 0});
    vecs.push_back('{1, 8'h99, 0, 0, 16'h0000, 8'h00, 0, 0, 1, 0, 16'h0000, 8'h00, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0});
    vecs.push_back('{0, 8'h00, 1, 0, 16'h0010, 8'h00, 1, 0, 1, 0, 16'h0010, 8'h00, 1, 0, 8'h00, 1, 0, 8'h00, 0, 1});
    vecs.push_back('{0, 8'h00, 1, 0, 16'h0099, 8'h00, 0, 0, 2, 0, 16'h0010, 8'h00, 0, 1, 8'hAA, 0, 0, 8'h00, 0, 1});
    vecs.push_back('{0, 8'h00, 1, 1, 16'h0012, 8'h77, 0, 0, 3, 0, 16'h0010, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 1});
    for (int k = 0; k < 5; k++)
      vecs.push_back('{0, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 0, 4, 0, 16'h0010, 8'h00, 0, 0, 8'h00, 0, 0, 8'hAA, 0, 1});
    vecs.push_back('{0, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 1, 4, 0, 16'h0010, 8'h00, 0, 0, 8'h00, 0, 1, 8'hAA, 0, 1});
    vecs.push_back('{0, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 1, 2, 0, 16'h0011, 8'h00, 0, 0, 8'h00, 0, 0, 8'hAA, 0, 1});
    vecs.push_back('{0, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 1, 3, 0, 16'h0011, 8'h00, 0, 0, 8'h00, 0, 0, 8'hAA, 0, 1});
    vecs.push_back('{0, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 1, 4, 0, 16'h0011, 8'h00, 0, 0, 8'h00, 0, 1, 8'h3C, 0, 1});
    vecs.push_back('{0, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 1, 5, 0, 16'h0000, 8'h00, 0, 0, 8'h00, 0, 0, 8'h3C, 1, 1});
    vecs.push_back('{0, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 0, 5, 0, 16'h0000, 8'h00, 0, 0, 8'h00, 0, 0, 8'h3C, 1, 1});
    vecs.push_back('{1, 8'h55, 0, 0, 16'h0000, 8'h00, 0, 0, 5, 1, 16'h0000, 8'h55, 0, 0, 8'h00, 0, 0, 8'h3C, 1, 1});
    vecs.push_back('{1, 8'h66, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 1, 16'h0001, 8'h66, 0, 0, 8'h00, 0, 0, 8'h3C, 0, 1});
    vecs.push_back('{1, 8'h77, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 1, 16'h0002, 8'h77, 0, 0, 8'h00, 0, 0, 8'h3C, 0, 1});
    vecs.push_back('{1, 8'h88, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 1, 16'h0003, 8'h88, 0, 0, 8'h00, 0, 0, 8'h3C, 0, 1});
    vecs.push_back('{0, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 0, 1, 0, 16'h0000, 8'h00, 0, 0, 8'h00, 1, 0, 8'h3C, 0, 1});
    vecs.push_back('{0, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 0, 2, 0, 16'h0010, 8'h00, 0, 0, 8'h00, 0, 0, 8'h3C, 0, 1});
    vecs.push_back('{0, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 0, 3, 0, 16'h0010, 8'h00, 0, 0, 8'h00, 0, 0, 8'h3C, 0, 1});
    vecs.push_back('{0, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 0, 4, 0, 16'h0010, 8'h00, 0, 0, 8'h00, 0, 0, 8'hAA, 0, 1});

    // Reset state, with rx_valid high to show clear blocks DRAM writes.
    clear = 1'b1;
    drive(1, 8'hE0, 1, 1, 16'h0005, 8'hE1, 0, 1);
    @(negedge clk_in);
    chk("rst phase", phase, 3'd0);
    chk("rst wren", dram_wren, 1'b0);
    chk("rst gnt", proc_gnt, 1'b0);
    chk("rst en", enable_processor, 1'b0);
    chk("rst tx_start", tx_start, 1'b0);
    chk("rst tx_data", tx_data, 8'h00);
    chk("rst rvalid", proc_rvalid, 1'b0);
    chk("rst frame_done", frame_done, 1'b0);
    chk("rst overrun", overrun, 1'b0);
    next_cycle();
    next_cycle();
    clear = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rxv, vecs[i].rxd, vecs[i].req, vecs[i].we, vecs[i].paddr, vecs[i].pwd,
            vecs[i].done, vecs[i].rdy);
      @(negedge clk_in);
      chk($sformatf("v%0d phase", i), phase, vecs[i].ph);
      chk($sformatf("v%0d wren", i), dram_wren, vecs[i].wren);
      chk($sformatf("v%0d addr", i), dram_addr, vecs[i].daddr);
      chk($sformatf("v%0d wdata", i), dram_wdata, vecs[i].dwd);
      chk($sformatf("v%0d gnt", i), proc_gnt, vecs[i].gnt);
      chk($sformatf("v%0d rvalid", i), proc_rvalid, vecs[i].rv);
      chk($sformatf("v%0d rdata", i), proc_rdata, vecs[i].rd);
      chk($sformatf("v%0d en", i), enable_processor, vecs[i].en);
      chk($sformatf("v%0d tx_start", i), tx_start, vecs[i].ts);
      chk($sformatf("v%0d tx_data", i), tx_data, vecs[i].txd);
      chk($sformatf("v%0d frame_done", i), frame_done, vecs[i].fd);
      chk($sformatf("v%0d overrun", i), overrun, vecs[i].ov);
      next_cycle();
    end

    // DRAM contents left by the table: frame-2 bytes at 0..1, processor writes at 0x10/0x11.
    chk("mem0", mem[16'h0000], 8'h55);
    chk("mem1", mem[16'h0001], 8'h66);
    chk("mem10", mem[16'h0010], 8'hAA);
    chk("mem11", mem[16'h0011], 8'h3C);

    // Still in TX_SEND: clear with tx_ready and rx_valid high must act immediately.
    chk("pre-clear phase", phase, 3'd4);
    drive(1, 8'hEE, 0, 0, 16'h0000, 8'h00, 0, 1);
    clear = 1'b1;
    #1;
    chk("clr phase", phase, 3'd0);
    chk("clr tx_start", tx_start, 1'b0);
    chk("clr wren", dram_wren, 1'b0);
    chk("clr tx_data", tx_data, 8'h00);
    chk("clr overrun", overrun, 1'b0);
    next_cycle();
    chk("clr hold mem0", mem[16'h0000], 8'h55);
    clear = 1'b0;

    // New frame loads from address 0 again.
    for (int b = 0; b < 4; b++) begin
      logic [7:0] byte_v;
      byte_v = 8'hA1 + 8'(b);
      drive(1, byte_v, 0, 0, 16'h0000, 8'h00, 0, 0);
      @(negedge clk_in);
      chk($sformatf("f3 b%0d wren", b), dram_wren, 1'b1);
      chk($sformatf("f3 b%0d addr", b), dram_addr, 16'(b));
      chk($sformatf("f3 b%0d wdata", b), dram_wdata, byte_v);
      next_cycle();
    end
    drive(0, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 0);
    @(negedge clk_in);
    chk("f3 run phase", phase, 3'd1);
    next_cycle();
    drive(0, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 0);
    @(negedge clk_in);
    chk("f3 txread phase", phase, 3'd2);
    chk("f3 txread addr", dram_addr, 16'h0010);
    chk("f3 mem0", mem[16'h0000], 8'hA1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
